mpsoc_oci_trace_packer: RTL

//   Parametrised successor to the per-CPU OCI test-bench trace monitor. Packs a stream
//   of CODE_W-bit debug trace codes into SLOTS-slot words (dct_buffer/dct_count).

---
 rtl/mpsoc_oci_trace_packer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mpsoc_oci_trace_packer.sv
// Per-CPU OCI trace packer: packs CODE_W-bit trace codes into SLOTS-slot words,
// queues them in a show-ahead FIFO and flushes the partial word when the test ends.
module mpsoc_oci_trace_packer #(
    parameter  int CODE_W     = 2,
    parameter  int SLOTS      = 15,
    parameter  int FIFO_DEPTH = 4,
    localparam int COUNT_W    = $clog2(SLOTS + 1),
    localparam int BUF_W      = CODE_W * SLOTS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               code_valid,
    input  logic [CODE_W-1:0]  code,
    input  logic               test_ending,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [BUF_W-1:0]   out_buffer,
    output logic [COUNT_W-1:0] out_count,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [COUNT_W-1:0] dct_count,
    output logic               overflow,
    output logic               test_has_ended
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_ENDED} state_t;

    state_t             r_state, w_state_nxt;
    logic [BUF_W-1:0]   r_buf, w_buf_nxt;
    logic [COUNT_W-1:0] r_count, w_count_nxt;
    logic               r_ovf, w_ovf_nxt;

    logic [BUF_W-1:0]   r_mem     [FIFO_DEPTH];
    logic [COUNT_W-1:0] r_mem_cnt [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr, r_rd;
    logic [PTR_W:0]     r_fcnt;

    logic               w_full, w_pop, w_space, w_push;
    logic [BUF_W-1:0]   w_code_ext, w_slot, w_push_data;
    logic [COUNT_W-1:0] w_push_cnt;

    assign w_code_ext = BUF_W'(code);
    assign w_slot     = w_code_ext << (CODE_W * r_count);
    assign w_full     = (r_fcnt == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop      = out_valid & out_ready;
    // A full FIFO still has room when its head leaves on the same edge.
    assign w_space    = ~w_full | w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_push      = 1'b0;
        w_push_data = r_buf | w_slot;
        w_push_cnt  = COUNT_W'(SLOTS);
        case (r_state)
            ST_RUN: begin
                if (code_valid) begin
                    if (r_count == COUNT_W'(SLOTS - 1)) begin
                        w_push      = w_space;
                        w_ovf_nxt   = r_ovf | ~w_space;
                        w_buf_nxt   = '0;
                        w_count_nxt = '0;
                    end else begin
                        w_buf_nxt   = r_buf | w_slot;
                        w_count_nxt = r_count + COUNT_W'(1);
                    end
                end
                if (test_ending)
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Partial words wait for space rather than being dropped.
                if (r_count != '0) begin
                    if (w_space) begin
                        w_push      = 1'b1;
                        w_push_data = r_buf;
                        w_push_cnt  = r_count;
                        w_buf_nxt   = '0;
                        w_count_nxt = '0;
                    end
                end else if (r_fcnt == '0) begin
                    w_state_nxt = ST_ENDED;
                end
            end
            ST_ENDED: ;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_buf   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fcnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i]     <= '0;
                r_mem_cnt[i] <= '0;
            end
        end else begin
            if (w_pop)
                r_rd <= r_rd + PTR_W'(1);
            if (w_push) begin
                r_mem[r_wr]     <= w_push_data;
                r_mem_cnt[r_wr] <= w_push_cnt;
                r_wr            <= r_wr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + (PTR_W+1)'(1);
                2'b01:   r_fcnt <= r_fcnt - (PTR_W+1)'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign out_valid      = (r_fcnt != '0);
    assign out_buffer     = out_valid ? r_mem[r_rd]     : '0;
    assign out_count      = out_valid ? r_mem_cnt[r_rd] : '0;
    assign dct_buffer     = r_buf;
    assign dct_count      = r_count;
    assign overflow       = r_ovf;
    assign test_has_ended = (r_state == ST_ENDED);

endmodule
